// File: rtl/regaddr_arbiter.sv
// Round-robin two-requester arbiter for the shared register-address mux.
// Each grant is held for ACC_CYCLES cycles, ending with a done pulse and one IDLE cycle.
module regaddr_arbiter #(
  parameter int ADDR_W     = 3,
  parameter int ACC_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic              req2,
  input  logic [ADDR_W-1:0] addr2,
  output logic              sel,
  output logic              gnt1,
  output logic              gnt2,
  output logic              done1,
  output logic              done2,
  output logic              busy,
  output logic [ADDR_W-1:0] addr_q
);

  typedef enum logic {IDLE, ACCESS} state_t;

  localparam logic [3:0] CNT_LOAD = 4'(ACC_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              sel_q, sel_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_r, addr_d;
  logic              gnt1_q, gnt1_d, gnt2_q, gnt2_d;
  logic              done1_q, done1_d, done2_q, done2_d;
  logic              winner;

  // On a tie the requester not recorded in last wins; otherwise the lone requester.
  assign winner = (req1 && req2) ? ~last_q : req2;

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block infers a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    addr_d  = addr_r;
    unique case (state_q)
      IDLE: begin
        if (req1 || req2) begin
          state_d = ACCESS;
          sel_d   = winner;
          addr_d  = winner ? addr2 : addr1;
          cnt_d   = CNT_LOAD;
        end
      end
      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = IDLE;
          last_d  = sel_q;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are computed from next state so they leave the flops with no input path.
    gnt1_d  = (state_d == ACCESS) && !sel_d;
    gnt2_d  = (state_d == ACCESS) &&  sel_d;
    done1_d = gnt1_d && (cnt_d == 4'd0);
    done2_d = gnt2_d && (cnt_d == 4'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      sel_q   <= 1'b0;
      last_q  <= 1'b1;
      addr_r  <= '0;
      gnt1_q  <= 1'b0;
      gnt2_q  <= 1'b0;
      done1_q <= 1'b0;
      done2_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      addr_r  <= addr_d;
      gnt1_q  <= gnt1_d;
      gnt2_q  <= gnt2_d;
      done1_q <= done1_d;
      done2_q <= done2_d;
    end
  end

  assign sel    = sel_q;
  assign gnt1   = gnt1_q;
  assign gnt2   = gnt2_q;
  assign done1  = done1_q;
  assign done2  = done2_q;
  assign busy   = gnt1_q | gnt2_q;
  assign addr_q = addr_r;

endmodule

// File: tb/tb_regaddr_arbiter.sv
// Self-checking bench: two arbiters (ACC_CYCLES=2 and 1) against a schedule-level model,
// plus directed literal checks for reset, single request, stability, mid-access reset and tie order.
module tb_regaddr_arbiter;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0][1:0]         rq;
  logic [1:0][1:0][AW-1:0] ad;
  logic g1[2], g2[2], d1[2], d2[2], bz[2], sl[2];
  logic [AW-1:0] aq[2];

  int  n_checks = 0;
  int  n_fail   = 0;
  bit  cmp_en   = 1'b0;

  always #5 clk = ~clk;

  regaddr_arbiter #(.ADDR_W(AW), .ACC_CYCLES(2)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .req1(rq[0][0]), .addr1(ad[0][0]), .req2(rq[0][1]), .addr2(ad[0][1]),
    .sel(sl[0]), .gnt1(g1[0]), .gnt2(g2[0]), .done1(d1[0]), .done2(d2[0]),
    .busy(bz[0]), .addr_q(aq[0])
  );

  regaddr_arbiter #(.ADDR_W(AW), .ACC_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .req1(rq[1][0]), .addr1(ad[1][0]), .req2(rq[1][1]), .addr2(ad[1][1]),
    .sel(sl[1]), .gnt1(g1[1]), .gnt2(g2[1]), .done1(d1[1]), .done2(d2[1]),
    .busy(bz[1]), .addr_q(aq[1])
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [9:0] outs(input int k);
    return {g1[k], g2[k], d1[k], d2[k], bz[k], sl[k], aq[k]};
  endfunction

  // Model: an access is a window of acc cycles starting at the grant edge; age counts up within it.
  bit            m_act[2];
  int            m_age[2];
  bit            m_own[2], m_last[2], m_sel[2];
  logic [AW-1:0] m_addr[2];
  bit            m_pdone[2][2];

  function automatic int acc_of(input int k);
    return (k == 0) ? 2 : 1;
  endfunction

  function automatic bit e_gnt(input int k, input int j);
    return m_act[k] && (m_own[k] == j[0]);
  endfunction

  function automatic bit e_done(input int k, input int j);
    return e_gnt(k, j) && (m_age[k] == acc_of(k) - 1);
  endfunction

  initial forever begin
    @(posedge clk or negedge rst_n);
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_act[k] = 1'b0; m_age[k] = 0; m_own[k] = 1'b0; m_last[k] = 1'b1;
        m_sel[k] = 1'b0; m_addr[k] = '0; m_pdone[k][0] = 1'b0; m_pdone[k][1] = 1'b0;
      end else begin
        m_pdone[k][0] = e_done(k, 0);
        m_pdone[k][1] = e_done(k, 1);
        if (m_act[k]) begin
          if (m_age[k] == acc_of(k) - 1) begin
            m_act[k]  = 1'b0;
            m_last[k] = m_own[k];
          end else begin
            m_age[k]++;
          end
        end else if (rq[k][0] || rq[k][1]) begin
          m_own[k]  = (rq[k][0] && rq[k][1]) ? !m_last[k] : rq[k][1];
          m_act[k]  = 1'b1;
          m_age[k]  = 0;
          m_sel[k]  = m_own[k];
          m_addr[k] = ad[k][m_own[k]];
        end
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("dut%0d gnt1", k),  16'(g1[k]), 16'(e_gnt(k, 0)));
        check($sformatf("dut%0d gnt2", k),  16'(g2[k]), 16'(e_gnt(k, 1)));
        check($sformatf("dut%0d done1", k), 16'(d1[k]), 16'(e_done(k, 0)));
        check($sformatf("dut%0d done2", k), 16'(d2[k]), 16'(e_done(k, 1)));
        check($sformatf("dut%0d busy", k),  16'(bz[k]), 16'(m_act[k]));
        check($sformatf("dut%0d sel", k),   16'(sl[k]), 16'(m_sel[k]));
        check($sformatf("dut%0d addr_q", k), 16'(aq[k]), 16'(m_addr[k]));
      end
    end
  end

  // Requester that always wants the path but obeys the drop-after-done handshake.
  task automatic drive_want(input int k);
    for (int j = 0; j < 2; j++)
      rq[k][j] = m_pdone[k][j] ? 1'b0 : 1'b1;
  endtask

  task automatic drive_random();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        if (m_pdone[k][j]) begin
          rq[k][j] = 1'b0;
        end else if (!rq[k][j]) begin
          if (!e_gnt(k, j) && $urandom_range(0, 2) == 0) begin
            rq[k][j] = 1'b1;
            ad[k][j] = AW'($urandom);
          end
        end else if (e_gnt(k, j)) begin
          if ($urandom_range(0, 3) == 0) ad[k][j] = AW'($urandom);
          if ($urandom_range(0, 7) == 0) rq[k][j] = 1'b0;
        end
      end
    end
  endtask

  logic tie_q[$];
  logic prev_busy;

  initial begin
    rst_n = 1'b0;
    rq    = '0;
    ad    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset dut0", 16'(outs(0)), 16'd0);
    check("reset dut1", 16'(outs(1)), 16'd0);
    cmp_en = 1'b1;
    rst_n  = 1'b1;

    // Single request from requester 1.
    rq[0][0] = 1'b1; ad[0][0] = 3'b101;
    @(posedge clk); @(negedge clk);
    check("single cyc1", 16'(outs(0)), 16'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101}));
    @(posedge clk); @(negedge clk);
    check("single cyc2", 16'(outs(0)), 16'({1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 3'b101}));
    @(posedge clk); #1 rq[0][0] = 1'b0;
    @(negedge clk);
    check("single idle", 16'(outs(0)), 16'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101}));

    // Requester 2 changes address and drops req mid-access.
    rq[0][1] = 1'b1; ad[0][1] = 3'b010;
    @(posedge clk); #1 ad[0][1] = 3'b111; rq[0][1] = 1'b0;
    @(negedge clk);
    check("stab cyc1", 16'(outs(0)), 16'({1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'b010}));
    @(posedge clk); @(negedge clk);
    check("stab cyc2", 16'(outs(0)), 16'({1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b010}));
    @(posedge clk); @(negedge clk);
    check("stab idle", 16'(outs(0)), 16'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010}));

    // Reset in the first cycle of a gnt1 window.
    rq[0][0] = 1'b1; ad[0][0] = 3'b110;
    @(posedge clk); #2;
    check("mid gnt1 before reset", 16'(g1[0]), 16'd1);
    rst_n = 1'b0; rq[0] = '0;
    #1;
    check("mid reset dut0", 16'(outs(0)), 16'd0);
    check("mid reset dut1", 16'(outs(1)), 16'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Continuous contention after reset: 1,2,1,2.
    rq[0] = 2'b11; ad[0][0] = 3'b001; ad[0][1] = 3'b100;
    prev_busy = 1'b0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1 drive_want(0);
      @(negedge clk);
      if (i == 0)
        check("tie first", 16'(outs(0)), 16'({1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'b001}));
      if (bz[0] && !prev_busy) tie_q.push_back(sl[0]);
      prev_busy = bz[0];
    end
    check("tie grant count", 16'(tie_q.size() >= 4), 16'd1);
    for (int i = 0; i < 4; i++)
      check($sformatf("tie order %0d", i), (i < tie_q.size()) ? 16'(tie_q[i]) : 16'hxxxx, 16'(i % 2));
    rq[0] = '0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    // ACC_CYCLES=1: gnt2 and done2 share one cycle.
    rq[1][1] = 1'b1; ad[1][1] = 3'b011;
    @(posedge clk); @(negedge clk);
    check("acc1 grant", 16'(outs(1)), 16'({1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 3'b011}));
    @(posedge clk); #1 rq[1][1] = 1'b0;
    @(negedge clk);
    check("acc1 idle", 16'(outs(1)), 16'({1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3'b011}));

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        check("rand reset dut0", 16'(outs(0)), 16'd0);
        check("rand reset dut1", 16'(outs(1)), 16'd0);
        rq = '0;
        @(posedge clk); #1 rst_n = 1'b1;
      end else begin
        drive_random();
      end
    end

    @(negedge clk);
    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
